inst_axi_bridge: RTL

Converts the instruction-fetch SRAM-like request/handshake into AXI4 read transactions. It sits directly downstream of the IF fetch controller and consumes its inst_req/inst_addr, returning inst_addr_ok, inst_data_ok and inst_rdata. It is read-only, single-beat, and allows one outstanding transaction. AXI write channels belong to the data-side bridge and are not part of this block.

---
 rtl/inst_axi_bridge.sv | 133 +++++++++++++
 1 files changed

// File: rtl/inst_axi_bridge.sv
// Instruction-fetch SRAM-like to AXI4 read bridge: single beat, one outstanding read.
// Optional macro INST_BRIDGE_ALIGN_CHECK_EN answers misaligned fetches locally with a bus error.
module inst_axi_bridge #(
    parameter int unsigned       ID_W        = 4,
    parameter logic [ID_W-1:0]   AR_ID       = '0,
    parameter logic [31:0]       RESET_PC_HI = 32'hbfc0_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_req,
    input  logic            inst_wr,
    input  logic [1:0]      inst_size,
    input  logic [31:0]     inst_addr,
    input  logic [31:0]     inst_wdata,
    output logic            inst_addr_ok,
    output logic            inst_data_ok,
    output logic [31:0]     inst_rdata,
    input  logic            inst_cancel,
    output logic            inst_bus_err,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic [1:0]      arlock,
    output logic [3:0]      arcache,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready
);

    typedef enum logic [1:0] {IDLE, AR, R, RESP} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        drop_q, drop_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Write-side, ID and last-beat inputs carry no meaning for a single-beat read-only bridge.
    logic unused_inputs;
    assign unused_inputs = ^{inst_wr, inst_wdata, rid, rlast, rresp[0]};

    assign arid       = AR_ID;
    assign arlen      = '0;
    assign arburst    = 2'b01;
    assign arlock     = '0;
    assign arcache    = '0;
    assign arprot     = '0;
    assign inst_rdata = rdata_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        drop_d       = drop_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_bus_err = 1'b0;
        arvalid      = 1'b0;
        araddr       = RESET_PC_HI;
        arsize       = {1'b0, size_q};
        rready       = 1'b0;
        unique case (state_q)
            IDLE: begin
                inst_addr_ok = inst_req;
                if (inst_req) begin
                    addr_d  = inst_addr;
                    size_d  = inst_size;
                    drop_d  = inst_cancel;
                    state_d = AR;
`ifdef INST_BRIDGE_ALIGN_CHECK_EN
                    if (inst_addr[1:0] != 2'b00) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = inst_cancel ? IDLE : RESP;
                    end
`endif
                end
            end
            AR: begin
                arvalid = 1'b1;
                araddr  = addr_q;
                drop_d  = drop_q | inst_cancel;
                if (arready) state_d = R;
            end
            R: begin
                rready = 1'b1;
                drop_d = drop_q | inst_cancel;
                if (rvalid) begin
                    rdata_d = rdata;
                    err_d   = rresp[1];
                    // A cancel arriving with the beat itself still drops the response.
                    state_d = (drop_q | inst_cancel) ? IDLE : RESP;
                end
            end
            RESP: begin
                inst_data_ok = 1'b1;
                inst_bus_err = err_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            drop_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            drop_q  <= drop_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule
